l1_writeback: RTL and testbench
===============================

// Module: l1_writeback
// PURPOSE
//  Direct-mapped, write-back, write-allocate L1 cache with multi-word lines, between core and memory controller.
//  A miss refills the whole line word-by-word over the memory-controller handshake, writing back a dirty victim first.
//  An uncached request (should_cache=0) bypasses the array as a single-word memory access.
// PARAMETERS
//  CACHE_BLOCK_SIZE_BYTES  16  line size in bytes; power of two, >=4; WORDS = CACHE_BLOCK_SIZE_BYTES/4
//  CACHE_LINES             16  number of lines; power of two, >=2
//  derived: OFFSET_BITS=$clog2(WORDS), INDEX_BITS=$clog2(CACHE_LINES), TAG_BITS=30-OFFSET_BITS-INDEX_BITS
// PORTS
//  clock                   in   1   single clock; all state updates on posedge
//  reset_n                 in   1   synchronous reset, active low
//  request                 in   1   core access valid; held with all core inputs stable until ready
//  address                 in   32  byte address; bits [1:0] ignored
//  input_data              in   32  write data
//  should_write            in   1   1=store, 0=load
//  should_cache            in   1   1=cacheable, 0=bypass
//  output_data             out  32  load data; valid when ready=1 and should_write=0
//  hit                     out  1   combinational tag match on a valid line (informational)
//  ready                   out  1   access complete this cycle
//  memory_request          out  1   memory-controller word access valid; held until memory_controller_ready
//  memory_write            out  1   1=write word to memory
//  memory_address          out  32  word-aligned address, [1:0]=0
//  memory_write_data       out  32  word to write
//  memory_controller_output_data  in 32  read word; sampled when memory_controller_ready=1
//  memory_controller_ready in   1   one-cycle completion pulse for the current memory word
// BEHAVIOUR
//  Fields: offset=address[OFFSET_BITS+1:2], index=next INDEX_BITS, tag=address[31:OFFSET_BITS+INDEX_BITS+2].
//  Per line: valid, dirty, tag, WORDS x 32b data. Reset clears every valid and dirty bit, state=IDLE;
//   registered outputs reset to 0 (memory_request=0, memory_write=0, memory_address=0, memory_write_data=0).
//  States: IDLE, WRITEBACK, REFILL, RESPOND, UNCACHED.
//  IDLE, no request: ready=0, memory_request=0.
//  IDLE, request, should_cache=1, hit: ready=1 combinationally that cycle (0-cycle latency);
//   load: output_data=line word[offset]; store: word[offset]<=input_data and dirty<=1 at the edge.
//  IDLE, request, should_cache=1, miss: victim valid&dirty -> WRITEBACK, else -> REFILL; counter<=0.
//  WRITEBACK: memory_write=1, memory_address={victim tag,index,counter,2'b00}, data=victim word[counter];
//   on memory_controller_ready: counter++; after word WORDS-1 -> REFILL, counter<=0.
//  REFILL: memory_write=0, memory_address={tag,index,counter,2'b00}; on memory_controller_ready
//   store word[counter]<=memory_controller_output_data; after last word: tag<=tag, valid<=1, dirty<=0 -> RESPOND.
//  RESPOND (1 cycle): ready=1; load returns word[offset]; store merges input_data, dirty<=1; -> IDLE.
//  UNCACHED (should_cache=0 in IDLE): one memory word at {address[31:2],2'b00}, memory_write=should_write;
//   on memory_controller_ready: ready=1 same cycle, output_data=memory_controller_output_data; -> IDLE.
//   Array untouched, even if the address hits a cached line (software keeps regions disjoint).
//  Words always transferred in order 0..WORDS-1; memory_request drops for >=0 cycles between words only
//   at state changes; within a state it stays high across consecutive words.
//  memory_controller_ready outside WRITEBACK/REFILL/UNCACHED is ignored.
//  hit is output for the presented address in every state; ready is never 1 outside IDLE-hit/RESPOND/UNCACHED.
//  Core request dropping mid-miss is illegal; behaviour undefined.
//  reset_n=0 in any state: aborts at the next edge, memory_request=0 that edge, partial refill discarded
//   (line stays invalid), dirty data not yet written back is lost.
//  Line boundary wrap: offset counter wraps only via state exit; never reads beyond WORDS-1.
// TESTING
//  1 reset, load 0x100 (cold) -> 4 memory reads 0x100..0x10C, then RESPOND ready=1, data=mem[0x100]; reload -> 0-cycle hit.
//  2 store 0xDEADBEEF to 0x104 on hit -> ready same cycle, no memory traffic; load 0x104 -> 0xDEADBEEF.
//  3 then load 0x504 (same index, new tag) -> 4 writes 0x100..0x10C (0x104 carries 0xDEADBEEF), then 4 reads 0x500..0x50C.
//  4 uncached load 0x2000 with should_cache=0 -> single read, ready with memory_controller_ready, hit stays 0 after.
//  5 memory_controller_ready delayed 0..5 random cycles per word -> memory_request held, data and address order intact.
//  6 reset_n=0 mid-REFILL after word 1 -> memory_request low next edge; reload same address -> full refill, correct data.

Source files
------------

// File: rtl/l1_writeback.sv
// ---------------------------------------------------------------------------
// l1_writeback
//   Direct-mapped, write-back, write-allocate L1 cache with multi-word lines.
//   It sits between a core and a word-wide memory controller. A miss refills
//   the whole line word by word, writing back a dirty victim line first.
//   Uncached requests (should_cache=0) bypass the array as a single-word
//   memory access.
//
// Ports
//   clock, reset_n                 clock, synchronous active-low reset
//   request, address, input_data,
//   should_write, should_cache     core access; held stable until ready
//   output_data                    load data, valid when ready=1 and load
//   hit                            tag match on a valid line (informational)
//   ready                          core access completes this cycle
//   memory_request, memory_write,
//   memory_address,
//   memory_write_data              registered word access to the controller
//   memory_controller_output_data  read word from the controller
//   memory_controller_ready        one-cycle completion pulse per word
//   debug_state                    current FSM state encoding
//
// Handshakes
//   Core side: request/inputs stay stable until ready=1; the access retires
//   at the clock edge where ready=1 is seen.
//   Memory side: memory_request and its address/data stay stable until the
//   cycle where memory_controller_ready=1; that edge retires the word.
// ---------------------------------------------------------------------------
module l1_writeback #(
  parameter int CACHE_BLOCK_SIZE_BYTES = 16,
  parameter int CACHE_LINES            = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        request,
  input  logic [31:0] address,
  input  logic [31:0] input_data,
  input  logic        should_write,
  input  logic        should_cache,
  output logic [31:0] output_data,
  output logic        hit,
  output logic        ready,
  output logic        memory_request,
  output logic        memory_write,
  output logic [31:0] memory_address,
  output logic [31:0] memory_write_data,
  input  logic [31:0] memory_controller_output_data,
  input  logic        memory_controller_ready,
  output logic [2:0]  debug_state
);

  localparam int WORDS       = CACHE_BLOCK_SIZE_BYTES / 4;
  localparam int OFFSET_BITS = $clog2(WORDS);
  localparam int INDEX_BITS  = $clog2(CACHE_LINES);
  localparam int TAG_BITS    = 30 - OFFSET_BITS - INDEX_BITS;
  // The word counter needs at least one bit even for single-word lines.
  localparam int CNT_W       = (OFFSET_BITS > 0) ? OFFSET_BITS : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WRITEBACK = 3'd1,
    S_REFILL    = 3'd2,
    S_RESPOND   = 3'd3,
    S_UNCACHED  = 3'd4
  } state_e;

  state_e                 state_q;
  logic [CNT_W-1:0]       count_q;
  logic [CACHE_LINES-1:0] valid_q;
  logic [CACHE_LINES-1:0] dirty_q;
  logic [TAG_BITS-1:0]    tag_q  [CACHE_LINES];
  logic [31:0]            data_q [CACHE_LINES][WORDS];
  logic                   mem_req_q;
  logic                   mem_we_q;
  logic [31:0]            mem_addr_q;
  logic [31:0]            mem_wdata_q;

  // Address decode of the presented core address.
  logic [29:0]           word_addr;
  logic [CNT_W-1:0]      offset;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic [CNT_W-1:0]      count_nxt;
  logic                  last_word;
  logic                  unused_addr_bits;

  assign word_addr        = address[31:2];
  assign offset           = word_addr[CNT_W-1:0] & LAST_WORD;
  assign index            = word_addr[OFFSET_BITS +: INDEX_BITS];
  assign tag              = word_addr[29 -: TAG_BITS];
  assign unused_addr_bits = ^address[1:0];
  assign count_nxt        = count_q + CNT_W'(1);
  assign last_word        = (count_q == LAST_WORD);

  // Byte address of word w of the line identified by tag t and index idx.
  function automatic logic [31:0] line_word_addr(input logic [TAG_BITS-1:0]   t,
                                                 input logic [INDEX_BITS-1:0] idx,
                                                 input logic [CNT_W-1:0]      w);
    logic [29:0] wa;
    wa = (30'(t) << (OFFSET_BITS + INDEX_BITS)) | (30'(idx) << OFFSET_BITS) |
         (30'(w) & 30'(LAST_WORD));
    return {wa, 2'b00};
  endfunction

  assign hit = valid_q[index] && (tag_q[index] == tag);

  always_comb begin
    ready = 1'b0;
    unique case (state_q)
      S_IDLE:     ready = request && should_cache && hit;
      S_RESPOND:  ready = 1'b1;
      S_UNCACHED: ready = memory_controller_ready;
      default:    ready = 1'b0;
    endcase
  end

  // Uncached loads forward the controller word; everything else reads the array.
  assign output_data = (state_q == S_UNCACHED) ? memory_controller_output_data
                                               : data_q[index][offset];

  assign memory_request    = mem_req_q;
  assign memory_write      = mem_we_q;
  assign memory_address    = mem_addr_q;
  assign memory_write_data = mem_wdata_q;
  assign debug_state       = state_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (request) begin
            if (!should_cache) begin
              state_q     <= S_UNCACHED;
              mem_req_q   <= 1'b1;
              mem_we_q    <= should_write;
              mem_addr_q  <= {address[31:2], 2'b00};
              mem_wdata_q <= input_data;
            end else if (hit) begin
              if (should_write) begin
                data_q[index][offset] <= input_data;
                dirty_q[index]        <= 1'b1;
              end
            end else if (valid_q[index] && dirty_q[index]) begin
              // Victim must reach memory before its line is overwritten.
              state_q     <= S_WRITEBACK;
              count_q     <= '0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= line_word_addr(tag_q[index], index, '0);
              mem_wdata_q <= data_q[index][0];
            end else begin
              state_q    <= S_REFILL;
              count_q    <= '0;
              mem_req_q  <= 1'b1;
              mem_we_q   <= 1'b0;
              mem_addr_q <= line_word_addr(tag, index, '0);
            end
          end
        end

        S_WRITEBACK: begin
          if (memory_controller_ready) begin
            if (last_word) begin
              // Request stays high: the refill starts without a gap.
              state_q    <= S_REFILL;
              count_q    <= '0;
              mem_we_q   <= 1'b0;
              mem_addr_q <= line_word_addr(tag, index, '0);
            end else begin
              count_q     <= count_nxt;
              mem_addr_q  <= line_word_addr(tag_q[index], index, count_nxt);
              mem_wdata_q <= data_q[index][count_nxt];
            end
          end
        end

        S_REFILL: begin
          if (memory_controller_ready) begin
            data_q[index][count_q] <= memory_controller_output_data;
            if (last_word) begin
              // Line becomes valid only once every word has arrived.
              state_q        <= S_RESPOND;
              count_q        <= '0;
              tag_q[index]   <= tag;
              valid_q[index] <= 1'b1;
              dirty_q[index] <= 1'b0;
              mem_req_q      <= 1'b0;
            end else begin
              count_q    <= count_nxt;
              mem_addr_q <= line_word_addr(tag, index, count_nxt);
            end
          end
        end

        S_RESPOND: begin
          if (should_write) begin
            data_q[index][offset] <= input_data;
            dirty_q[index]        <= 1'b1;
          end
          state_q <= S_IDLE;
        end

        S_UNCACHED: begin
          if (memory_controller_ready) begin
            state_q   <= S_IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end
        end

        default: begin
          state_q   <= S_IDLE;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l1_writeback.sv
// ---------------------------------------------------------------------------
// tb_l1_writeback
//   Directed bench for l1_writeback. A behavioural memory controller answers
//   word requests with a configurable random delay, logs every transferred
//   word and flags any request that changes or drops before completion.
//   Each scenario task drives the core port and checks its own results.
// ---------------------------------------------------------------------------
module tb_l1_writeback;

  // Clock / reset
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  // Core side
  logic        request;
  logic [31:0] address;
  logic [31:0] input_data;
  logic        should_write;
  logic        should_cache;
  logic [31:0] output_data;
  logic        hit;
  logic        ready;

  // Memory side
  logic        memory_request;
  logic        memory_write;
  logic [31:0] memory_address;
  logic [31:0] memory_write_data;
  logic [31:0] memory_controller_output_data = 32'h0;
  logic        memory_controller_ready = 1'b0;
  logic [2:0]  debug_state;

  int total = 0;
  int bad   = 0;

  l1_writeback #(
    .CACHE_BLOCK_SIZE_BYTES(16),
    .CACHE_LINES(16)
  ) dut (
    .clock                         (clock),
    .reset_n                       (reset_n),
    .request                       (request),
    .address                       (address),
    .input_data                    (input_data),
    .should_write                  (should_write),
    .should_cache                  (should_cache),
    .output_data                   (output_data),
    .hit                           (hit),
    .ready                         (ready),
    .memory_request                (memory_request),
    .memory_write                  (memory_write),
    .memory_address                (memory_address),
    .memory_write_data             (memory_write_data),
    .memory_controller_output_data (memory_controller_output_data),
    .memory_controller_ready       (memory_controller_ready),
    .debug_state                   (debug_state)
  );

  // Background content of memory words never written.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // Memory controller model
  int unsigned max_delay = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] log_addr [256];
  logic        log_we   [256];
  logic [31:0] log_data [256];
  int          log_n     = 0;
  int          hold_errs = 0;
  int unsigned wait_cnt  = 0;
  logic        pend      = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  logic        pend_we   = 1'b0;

  always @(negedge clock) begin
    if (!reset_n) begin
      memory_controller_ready = 1'b0;
      wait_cnt = 0;
      pend = 1'b0;
    end else if (memory_controller_ready) begin
      memory_controller_ready = 1'b0;
      pend = 1'b0;
    end else if (memory_request) begin
      if (pend && (memory_address !== pend_addr || memory_write !== pend_we)) hold_errs++;
      pend      = 1'b1;
      pend_addr = memory_address;
      pend_we   = memory_write;
      if (wait_cnt == 0) begin
        if (log_n < 256) begin
          log_addr[log_n] = memory_address;
          log_we[log_n]   = memory_write;
          log_data[log_n] = memory_write_data;
          log_n++;
        end
        if (memory_write) begin
          mem[memory_address] = memory_write_data;
          memory_controller_output_data = 32'h0;
        end else if (mem.exists(memory_address)) begin
          memory_controller_output_data = mem[memory_address];
        end else begin
          memory_controller_output_data = mem_val(memory_address);
        end
        memory_controller_ready = 1'b1;
        wait_cnt = $urandom_range(max_delay, 0);
      end else begin
        wait_cnt--;
      end
    end else begin
      if (pend) hold_errs++;
      pend = 1'b0;
    end
  end

  // Driver: one core access, bounded wait for ready.
  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic we,
                        input logic c, output logic [31:0] rd, output int lat,
                        output logic hit_seen);
    @(negedge clock);
    address = a; input_data = d; should_write = we; should_cache = c; request = 1'b1;
    #1;
    lat = 0;
    while (!ready && lat < 300) begin
      @(negedge clock);
      #1;
      lat++;
    end
    rd = output_data;
    hit_seen = hit;
    @(posedge clock);
    #1;
    request = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; request = 1'b0; address = 32'h100; input_data = 32'h0;
    should_write = 1'b0; should_cache = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    total++; if (memory_request !== 1'b0) begin bad++; $display("FAIL rst_mreq: got %b want 0", memory_request); end
    total++; if (memory_write !== 1'b0) begin bad++; $display("FAIL rst_mwe: got %b want 0", memory_write); end
    total++; if (memory_address !== 32'h0) begin bad++; $display("FAIL rst_maddr: got %h want 0", memory_address); end
    total++; if (memory_write_data !== 32'h0) begin bad++; $display("FAIL rst_mwdata: got %h want 0", memory_write_data); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", ready); end
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL rst_hit: got %b want 0", hit); end
    total++; if (debug_state !== 3'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", debug_state); end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_cold_load();
    logic [31:0] rd; int lat; logic hs; int base;
    base = log_n;
    access(32'h100, 32'h0, 1'b0, 1'b1, rd, lat, hs);
    total++; if (lat >= 300) begin bad++; $display("FAIL cold_timeout: got %0d cycles want <300", lat); end
    total++; if (log_n - base != 4) begin bad++; $display("FAIL cold_words: got %0d want 4", log_n - base); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (log_addr[base+i] !== 32'h100 + 32'(4*i) || log_we[base+i] !== 1'b0) begin
        bad++; $display("FAIL cold_addr%0d: got %h/%b want %h/0", i, log_addr[base+i], log_we[base+i], 32'h100 + 32'(4*i));
      end
    end
    total++; if (rd !== mem_val(32'h100)) begin bad++; $display("FAIL cold_data: got %h want %h", rd, mem_val(32'h100)); end
    base = log_n;
    access(32'h100, 32'h0, 1'b0, 1'b1, rd, lat, hs);
    total++; if (lat != 0) begin bad++; $display("FAIL reload_lat: got %0d want 0", lat); end
    total++; if (hs !== 1'b1) begin bad++; $display("FAIL reload_hit: got %b want 1", hs); end
    total++; if (rd !== mem_val(32'h100)) begin bad++; $display("FAIL reload_data: got %h want %h", rd, mem_val(32'h100)); end
    total++; if (log_n != base) begin bad++; $display("FAIL reload_traffic: got %0d words want 0", log_n - base); end
  endtask

  task automatic test_store_hit();
    logic [31:0] rd; int lat; logic hs; int base;
    base = log_n;
    access(32'h104, 32'hDEADBEEF, 1'b1, 1'b1, rd, lat, hs);
    total++; if (lat != 0) begin bad++; $display("FAIL store_lat: got %0d want 0", lat); end
    access(32'h104, 32'h0, 1'b0, 1'b1, rd, lat, hs);
    total++; if (lat != 0) begin bad++; $display("FAIL store_reload_lat: got %0d want 0", lat); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL store_data: got %h want deadbeef", rd); end
    total++; if (log_n != base) begin bad++; $display("FAIL store_traffic: got %0d words want 0", log_n - base); end
  endtask

  task automatic test_dirty_evict();
    logic [31:0] rd; int lat; logic hs; int base; logic [31:0] ea; logic [31:0] ed;
    base = log_n;
    access(32'h504, 32'h0, 1'b0, 1'b1, rd, lat, hs);
    total++; if (log_n - base != 8) begin bad++; $display("FAIL evict_words: got %0d want 8", log_n - base); end
    for (int i = 0; i < 4; i++) begin
      ea = 32'h100 + 32'(4*i);
      ed = (i == 1) ? 32'hDEADBEEF : mem_val(ea);
      total++;
      if (log_addr[base+i] !== ea || log_we[base+i] !== 1'b1 || log_data[base+i] !== ed) begin
        bad++; $display("FAIL evict_wb%0d: got %h/%b/%h want %h/1/%h", i, log_addr[base+i], log_we[base+i], log_data[base+i], ea, ed);
      end
    end
    for (int i = 0; i < 4; i++) begin
      ea = 32'h500 + 32'(4*i);
      total++;
      if (log_addr[base+4+i] !== ea || log_we[base+4+i] !== 1'b0) begin
        bad++; $display("FAIL evict_rf%0d: got %h/%b want %h/0", i, log_addr[base+4+i], log_we[base+4+i], ea);
      end
    end
    total++; if (rd !== mem_val(32'h504)) begin bad++; $display("FAIL evict_data: got %h want %h", rd, mem_val(32'h504)); end
  endtask

  task automatic test_uncached();
    logic [31:0] rd; int lat; logic hs; int base;
    base = log_n;
    access(32'h2000, 32'h0, 1'b0, 1'b0, rd, lat, hs);
    total++; if (log_n - base != 1) begin bad++; $display("FAIL unc_words: got %0d want 1", log_n - base); end
    total++; if (log_addr[base] !== 32'h2000 || log_we[base] !== 1'b0) begin
      bad++; $display("FAIL unc_addr: got %h/%b want 00002000/0", log_addr[base], log_we[base]); end
    total++; if (rd !== mem_val(32'h2000)) begin bad++; $display("FAIL unc_data: got %h want %h", rd, mem_val(32'h2000)); end
    @(negedge clock); #1;
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL unc_hit: got %b want 0", hit); end
    base = log_n;
    access(32'h3000, 32'h12345678, 1'b1, 1'b0, rd, lat, hs);
    total++; if (log_n - base != 1 || log_we[base] !== 1'b1 || log_data[base] !== 32'h12345678) begin
      bad++; $display("FAIL unc_store: got %0d/%b/%h want 1/1/12345678", log_n - base, log_we[base], log_data[base]); end
    access(32'h3000, 32'h0, 1'b0, 1'b0, rd, lat, hs);
    total++; if (rd !== 32'h12345678) begin bad++; $display("FAIL unc_reload: got %h want 12345678", rd); end
    // Uncached store into a cached line must leave the array alone.
    access(32'h508, 32'hCAFEF00D, 1'b1, 1'b0, rd, lat, hs);
    access(32'h508, 32'h0, 1'b0, 1'b1, rd, lat, hs);
    total++; if (lat != 0 || rd !== mem_val(32'h508)) begin
      bad++; $display("FAIL unc_untouched: got %0d/%h want 0/%h", lat, rd, mem_val(32'h508)); end
  endtask

  task automatic test_random_delay();
    logic [31:0] rd; int lat; logic hs; int base; logic [31:0] ea; logic [31:0] ed;
    max_delay = 5;
    base = log_n;
    access(32'h1A8, 32'h0, 1'b0, 1'b1, rd, lat, hs);
    total++; if (lat >= 300) begin bad++; $display("FAIL dly_timeout: got %0d cycles want <300", lat); end
    total++; if (log_n - base != 4) begin bad++; $display("FAIL dly_words: got %0d want 4", log_n - base); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (log_addr[base+i] !== 32'h1A0 + 32'(4*i)) begin
        bad++; $display("FAIL dly_addr%0d: got %h want %h", i, log_addr[base+i], 32'h1A0 + 32'(4*i)); end
    end
    total++; if (rd !== mem_val(32'h1A8)) begin bad++; $display("FAIL dly_data: got %h want %h", rd, mem_val(32'h1A8)); end
    // Clean victim: store miss refills without a writeback.
    base = log_n;
    access(32'h2A4, 32'h000055AA, 1'b1, 1'b1, rd, lat, hs);
    total++; if (log_n - base != 4 || log_we[base] !== 1'b0 || log_addr[base] !== 32'h2A0) begin
      bad++; $display("FAIL dly_clean: got %0d/%b/%h want 4/0/000002a0", log_n - base, log_we[base], log_addr[base]); end
    base = log_n;
    access(32'h6A0, 32'h0, 1'b0, 1'b1, rd, lat, hs);
    total++; if (log_n - base != 8) begin bad++; $display("FAIL dly_evict_words: got %0d want 8", log_n - base); end
    for (int i = 0; i < 4; i++) begin
      ea = 32'h2A0 + 32'(4*i);
      ed = (i == 1) ? 32'h000055AA : mem_val(ea);
      total++;
      if (log_addr[base+i] !== ea || log_we[base+i] !== 1'b1 || log_data[base+i] !== ed) begin
        bad++; $display("FAIL dly_wb%0d: got %h/%b/%h want %h/1/%h", i, log_addr[base+i], log_we[base+i], log_data[base+i], ea, ed);
      end
      total++;
      if (log_addr[base+4+i] !== 32'h6A0 + 32'(4*i) || log_we[base+4+i] !== 1'b0) begin
        bad++; $display("FAIL dly_rf%0d: got %h/%b want %h/0", i, log_addr[base+4+i], log_we[base+4+i], 32'h6A0 + 32'(4*i));
      end
    end
    total++; if (rd !== mem_val(32'h6A0)) begin bad++; $display("FAIL dly_evict_data: got %h want %h", rd, mem_val(32'h6A0)); end
    total++; if (hold_errs != 0) begin bad++; $display("FAIL dly_hold: got %0d violations want 0", hold_errs); end
    max_delay = 0;
  endtask

  task automatic test_reset_mid_refill();
    logic [31:0] rd; int lat; logic hs; int base; int n;
    base = log_n;
    @(negedge clock);
    address = 32'h7C0; input_data = 32'h0; should_write = 1'b0; should_cache = 1'b1; request = 1'b1;
    n = 0;
    while (log_n - base < 2 && n < 100) begin
      @(negedge clock); #1; n++;
    end
    total++; if (n >= 100) begin bad++; $display("FAIL mid_timeout: got %0d words want 2", log_n - base); end
    @(posedge clock); #1;
    reset_n = 1'b0; request = 1'b0;
    @(posedge clock); #1;
    total++; if (memory_request !== 1'b0) begin bad++; $display("FAIL mid_mreq: got %b want 0", memory_request); end
    total++; if (debug_state !== 3'd0) begin bad++; $display("FAIL mid_state: got %0d want 0", debug_state); end
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL mid_partial_hit: got %b want 0", hit); end
    address = 32'h504; #1;
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL mid_cleared_hit: got %b want 0", hit); end
    total++; if (log_n - base != 2) begin bad++; $display("FAIL mid_words: got %0d want 2", log_n - base); end
    base = log_n;
    access(32'h7C0, 32'h0, 1'b0, 1'b1, rd, lat, hs);
    total++; if (log_n - base != 4) begin bad++; $display("FAIL mid_refill_words: got %0d want 4", log_n - base); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (log_addr[base+i] !== 32'h7C0 + 32'(4*i)) begin
        bad++; $display("FAIL mid_addr%0d: got %h want %h", i, log_addr[base+i], 32'h7C0 + 32'(4*i)); end
    end
    total++; if (rd !== mem_val(32'h7C0)) begin bad++; $display("FAIL mid_data: got %h want %h", rd, mem_val(32'h7C0)); end
  endtask

  initial begin
    test_reset();
    test_cold_load();
    test_store_hit();
    test_dirty_evict();
    test_uncached();
    test_random_delay();
    test_reset_mid_refill();
    repeat (2) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

endmodule
